// File: rtl/pixel_readout_pkg.sv
// Shared types and helpers for the pixel readout capture path.
// Holds the K28.5 header byte, both FSM state enums and the FIFO word packer.
package pixel_readout_pkg;

   localparam logic [7:0] K28_5 = 8'hBC;

   typedef enum logic [1:0] {
      C_IDLE,
      C_ARM,
      C_CAPTURE,
      C_DONE
   } cap_state_t;

   typedef enum logic [1:0] {
      L_UNLOCKED,
      L_CHECK,
      L_LOCKED
   } lock_state_t;

   // {k3,b3,k2,b2,k1,b1,k0,b0}, lane 0 = earliest byte
   function automatic logic [35:0] pack_word(
      input logic [3:0]  k,
      input logic [31:0] b
   );
      return {k[3], b[31:24], k[2], b[23:16],
              k[1], b[15:8],  k[0], b[7:0]};
   endfunction

endpackage

// File: rtl/frame_capture_sequencer_if.sv
// Pixel-data / FIFO / control bundle of the frame capture sequencer.
// slave: the sequencer side; master: the chip+FIFO+control side.
interface frame_capture_sequencer_if #(
   parameter int NFRAME_W = 8
);
   logic [7:0]          din;
   logic                start;
   logic [NFRAME_W-1:0] nframes;
   logic                abort;
   logic                fifo_full;
   logic                fifo_wr_en;
   logic [35:0]         data_out;
   logic                locked;
   logic                busy;
   logic                done;
   logic                overflow;
   logic                lock_err;
   logic [NFRAME_W-1:0] frames_captured;

   modport master (
      output din, start, nframes, abort, fifo_full,
      input  fifo_wr_en, data_out, locked, busy, done,
      input  overflow, lock_err, frames_captured
   );

   modport slave (
      input  din, start, nframes, abort, fifo_full,
      output fifo_wr_en, data_out, locked, busy, done,
      output overflow, lock_err, frames_captured
   );

endinterface

// File: rtl/frame_lock_tracker.sv
// Frame alignment tracker: registers din, counts byte position, runs lock FSM.
// Ports: clk, rst, din in; din_q, hdr (din_q is header), at_slot, locked out.
module frame_lock_tracker
   import pixel_readout_pkg::*;
#(
   parameter int         FRAME_WIDTH = 48,
   parameter logic [7:0] HEADER      = K28_5,
   parameter int         LOCK_COUNT  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   output logic [7:0] din_q,
   output logic       hdr,
   output logic       at_slot,
   output logic       locked
);
   localparam int PW = $clog2(FRAME_WIDTH);
   localparam int HW = $clog2(LOCK_COUNT + 1);

   lock_state_t   state;
   logic [PW-1:0] pos;
   logic [HW-1:0] hits;

   // pos is the frame position of the byte now in din_q
   assign hdr     = (din_q == HEADER);
   assign at_slot = (state != L_UNLOCKED) && (pos == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= L_UNLOCKED;
         din_q  <= '0;
         pos    <= '0;
         hits   <= '0;
         locked <= 1'b0;
      end else begin
         din_q <= din;
         pos   <= (pos == PW'(FRAME_WIDTH - 1)) ? '0 : pos + 1'b1;
         unique case (state)
            L_UNLOCKED: begin
               if (hdr) begin
                  state <= L_CHECK;
                  pos   <= PW'(1);
                  hits  <= HW'(1);
               end
            end
            L_CHECK: begin
               if (at_slot) begin
                  if (!hdr) begin
                     state <= L_UNLOCKED;
                  end else if (hits == HW'(LOCK_COUNT - 1)) begin
                     state  <= L_LOCKED;
                     hits   <= HW'(LOCK_COUNT);
                     locked <= 1'b1;
                  end else begin
                     hits <= hits + 1'b1;
                  end
               end
            end
            L_LOCKED: begin
               if (at_slot && !hdr) begin
                  state  <= L_UNLOCKED;
                  locked <= 1'b0;
               end
            end
            default: state <= L_UNLOCKED;
         endcase
      end
   end

endmodule

// File: rtl/frame_capture_sequencer.sv
// Captures N aligned pixel frames into 36-bit FIFO words with status flags.
// Ports: clk, rst; bus (slave): din/start/nframes/abort/fifo_full in, FIFO+status out.
module frame_capture_sequencer
   import pixel_readout_pkg::*;
#(
   parameter int         FRAME_WIDTH = 48,
   parameter logic [7:0] HEADER      = K28_5,
   parameter int         LOCK_COUNT  = 4,
   parameter int         NFRAME_W    = 8,
   parameter int         FIFO_WIDTH  = 36
) (
   input logic                      clk,
   input logic                      rst,
   frame_capture_sequencer_if.slave bus
);
   localparam int WPF = FRAME_WIDTH / 4;
   localparam int WW  = (WPF > 1) ? $clog2(WPF) : 1;

   logic [7:0] din_q;
   logic       hdr;
   logic       at_slot;
   logic       locked;

   frame_lock_tracker #(
      .FRAME_WIDTH(FRAME_WIDTH),
      .HEADER     (HEADER),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_lock (
      .clk    (clk),
      .rst    (rst),
      .din    (bus.din),
      .din_q  (din_q),
      .hdr    (hdr),
      .at_slot(at_slot),
      .locked (locked)
   );

   cap_state_t          state;
   logic [NFRAME_W-1:0] target;
   logic [NFRAME_W-1:0] fc;
   logic [NFRAME_W-1:0] fc_inc;
   logic [1:0]          lane;
   logic [23:0]         lo;
   logic [2:0]          kf;
   logic [WW-1:0]       wcnt;
   logic                kbit;
   logic [FIFO_WIDTH-1:0] word;
   logic                wr_en;
   logic [FIFO_WIDTH-1:0] dout;
   logic                busy;
   logic                done;
   logic                ovf;
   logic                lerr;

   // only a header sitting on the expected slot carries k=1
   assign kbit   = hdr && at_slot;
   assign word   = pack_word({kbit, kf}, {din_q, lo});
   assign fc_inc = (&fc) ? fc : fc + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= C_IDLE;
         target <= '0;
         fc     <= '0;
         lane   <= '0;
         lo     <= '0;
         kf     <= '0;
         wcnt   <= '0;
         wr_en  <= 1'b0;
         dout   <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         ovf    <= 1'b0;
         lerr   <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         unique case (state)
            C_IDLE: begin
               if (bus.start) begin
                  target <= bus.nframes;
                  fc     <= '0;
                  ovf    <= 1'b0;
                  lerr   <= 1'b0;
                  if (bus.nframes == '0) begin
                     done <= 1'b1;
                  end else begin
                     state <= C_ARM;
                     busy  <= 1'b1;
                  end
               end
            end
            C_ARM: begin
               if (bus.abort) begin
                  state <= C_IDLE;
                  busy  <= 1'b0;
               end else if (locked && kbit) begin
                  lo[7:0] <= din_q;
                  kf      <= 3'b001;
                  lane    <= 2'd1;
                  wcnt    <= '0;
                  state   <= C_CAPTURE;
               end
            end
            C_CAPTURE: begin
               if (bus.abort) begin
                  state <= C_IDLE;
                  busy  <= 1'b0;
               end else if (at_slot && !hdr) begin
                  lerr  <= 1'b1;
                  state <= C_IDLE;
                  busy  <= 1'b0;
               end else begin
                  lane <= lane + 2'd1;
                  unique case (lane)
                     2'd0: begin
                        lo[7:0] <= din_q;
                        kf[0]   <= kbit;
                     end
                     2'd1: begin
                        lo[15:8] <= din_q;
                        kf[1]    <= kbit;
                     end
                     2'd2: begin
                        lo[23:16] <= din_q;
                        kf[2]     <= kbit;
                     end
                     2'd3: begin
                        // a full FIFO drops this word but capture keeps going
                        if (bus.fifo_full) begin
                           ovf <= 1'b1;
                        end else begin
                           wr_en <= 1'b1;
                           dout  <= word;
                        end
                        if (wcnt == WW'(WPF - 1)) begin
                           wcnt <= '0;
                           fc   <= fc_inc;
                           if (fc_inc == target) begin
                              state <= C_DONE;
                              done  <= 1'b1;
                           end
                        end else begin
                           wcnt <= wcnt + 1'b1;
                        end
                     end
                  endcase
               end
            end
            C_DONE: begin
               state <= C_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= C_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_wr_en      = wr_en;
   assign bus.data_out        = dout;
   assign bus.locked          = locked;
   assign bus.busy            = busy;
   assign bus.done            = done;
   assign bus.overflow        = ovf;
   assign bus.lock_err        = lerr;
   assign bus.frames_captured = fc;

endmodule

// File: tb/tb_frame_capture_sequencer.sv
// Testbench for frame_capture_sequencer: frame stream with random payload,
// expected FIFO words derived from byte positions in the stream.
module tb_frame_capture_sequencer;
   import pixel_readout_pkg::*;

   localparam int FW = 48;
   localparam int B  = 6;
   localparam int NS = 1400;

   typedef struct {
      int          t;
      logic [35:0] w;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   frame_capture_sequencer_if #(.NFRAME_W(8)) bus ();

   frame_capture_sequencer dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   exp_t       exp_q[$];
   logic [7:0] sb[NS];
   int t = 0;
   int fs = 0;
   int fe = 0;
   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int a;
   int r;

   function automatic int hpos(int f);
      return B + FW * f;
   endfunction

   function automatic logic [7:0] payload();
      logic [7:0] v;
      do v = 8'($urandom); while (v == K28_5);
      return v;
   endfunction

   // word whose earliest byte is stream index idx
   function automatic logic [35:0] model_word(int idx);
      logic [35:0] res;
      int p;
      logic k;
      res = '0;
      for (int l = 0; l < 4; l++) begin
         p = idx + l;
         k = ((p - B) % FW == 0) && (sb[p] == K28_5);
         res[9*l +: 9] = {k, sb[p]};
      end
      return res;
   endfunction

   task automatic chk(string tag, logic [35:0] obs, logic [35:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // word w of frame f is strobed in the sample after its 4th byte + 1
   task automatic push_frames(int f0, int n, int cut);
      int b;
      int vt;
      for (int f = f0; f < f0 + n; f++) begin
         for (int w = 0; w < FW / 4; w++) begin
            b  = hpos(f) + 4 * w;
            vt = b + 4;
            if (vt < cut && !(vt >= fs && vt < fe))
               exp_q.push_back('{vt, model_word(b)});
         end
      end
   endtask

   task automatic step();
      bus.din       = sb[t];
      bus.fifo_full = (t >= fs) && (t < fe);
      @(posedge clk);
      #1;
      if (exp_q.size() != 0 && exp_q[0].t == t) begin
         chk("wr_en", 36'(bus.fifo_wr_en), 36'd1);
         chk("word", bus.data_out, exp_q[0].w);
         void'(exp_q.pop_front());
      end else begin
         chk("no_wr", 36'(bus.fifo_wr_en), 36'd0);
      end
      if (bus.done === 1'b1) done_cnt++;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst       = 1'b0;
      t++;
   endtask

   task automatic run_to(int k);
      while (t <= k) step();
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         if (i < B) sb[i] = payload();
         else if ((i - B) % FW == 0) sb[i] = K28_5;
         else if (i - B < 7 * FW) sb[i] = 8'((i - B) % FW - 1);
         else sb[i] = payload();
      end
      sb[hpos(12)] = 8'h3C;

      rst           = 1'b1;
      bus.din       = '0;
      bus.start     = 1'b0;
      bus.nframes   = '0;
      bus.abort     = 1'b0;
      bus.fifo_full = 1'b0;

      run_to(0);
      chk("rst_locked", 36'(bus.locked), 36'd0);
      chk("rst_busy", 36'(bus.busy), 36'd0);
      chk("rst_done", 36'(bus.done), 36'd0);
      chk("rst_ovf", 36'(bus.overflow), 36'd0);
      chk("rst_lerr", 36'(bus.lock_err), 36'd0);
      chk("rst_fc", 36'(bus.frames_captured), 36'd0);
      chk("rst_dout", bus.data_out, 36'd0);
      rst = 1'b1;
      run_to(1);

      // lock acquisition on the 4th header
      run_to(hpos(3));
      chk("lock_pre", 36'(bus.locked), 36'd0);
      run_to(hpos(3) + 1);
      chk("lock_acq", 36'(bus.locked), 36'd1);

      // two-frame capture, start while busy ignored
      done_cnt = 0;
      run_to(hpos(4) - 4);
      bus.start   = 1'b1;
      bus.nframes = 8'd2;
      push_frames(4, 2, NS);
      run_to(hpos(4) - 3);
      chk("t2_busy", 36'(bus.busy), 36'd1);
      run_to(hpos(4) + 4);
      chk("t2_word0", bus.data_out, {9'h002, 9'h001, 9'h000, 9'h1BC});
      run_to(hpos(4) + 19);
      bus.start   = 1'b1;
      bus.nframes = 8'd1;
      run_to(hpos(6));
      chk("t2_done", 36'(bus.done), 36'd1);
      chk("t2_fc", 36'(bus.frames_captured), 36'd2);
      run_to(hpos(6) + 1);
      chk("t2_idle", 36'(bus.busy), 36'd0);
      chk("t2_ndone", 36'(done_cnt), 36'd1);

      // fifo_full window of 10 cycles mid-frame
      fs = hpos(7) + 20 + int'($urandom_range(0, 8));
      fe = fs + 10;
      done_cnt = 0;
      run_to(hpos(7) - 11);
      bus.start   = 1'b1;
      bus.nframes = 8'd2;
      push_frames(7, 2, NS);
      run_to(fs - 1);
      chk("t3_ovf_pre", 36'(bus.overflow), 36'd0);
      run_to(hpos(9));
      chk("t3_ovf", 36'(bus.overflow), 36'd1);
      chk("t3_fc", 36'(bus.frames_captured), 36'd2);
      chk("t3_done", 36'(bus.done), 36'd1);
      fs = 0;
      fe = 0;

      // header corrupted during capture of 5 frames
      run_to(hpos(9) + 4);
      bus.start   = 1'b1;
      bus.nframes = 8'd5;
      push_frames(10, 2, NS);
      done_cnt = 0;
      run_to(hpos(9) + 5);
      chk("t4_ovf_clr", 36'(bus.overflow), 36'd0);
      chk("t4_busy", 36'(bus.busy), 36'd1);
      run_to(hpos(12));
      chk("t4_lock_pre", 36'(bus.locked), 36'd1);
      chk("t4_lerr_pre", 36'(bus.lock_err), 36'd0);
      run_to(hpos(12) + 1);
      chk("t4_lerr", 36'(bus.lock_err), 36'd1);
      chk("t4_busy0", 36'(bus.busy), 36'd0);
      chk("t4_lock0", 36'(bus.locked), 36'd0);
      chk("t4_fc", 36'(bus.frames_captured), 36'd2);
      run_to(hpos(13));
      chk("t4_ndone", 36'(done_cnt), 36'd0);

      // relock, abort, nframes=0, start+abort
      run_to(hpos(16));
      chk("t5_lock_pre", 36'(bus.locked), 36'd0);
      run_to(hpos(16) + 1);
      chk("t5_relock", 36'(bus.locked), 36'd1);
      done_cnt = 0;
      run_to(hpos(17) - 3);
      bus.start   = 1'b1;
      bus.nframes = 8'd3;
      a = hpos(17) + 6;
      push_frames(17, 3, a);
      run_to(a - 1);
      chk("t5_busy", 36'(bus.busy), 36'd1);
      bus.abort = 1'b1;
      run_to(a);
      chk("t5_abort", 36'(bus.busy), 36'd0);
      run_to(a + 2);
      bus.start   = 1'b1;
      bus.nframes = 8'd0;
      run_to(a + 3);
      chk("t5_zdone", 36'(bus.done), 36'd1);
      chk("t5_zbusy", 36'(bus.busy), 36'd0);
      run_to(a + 5);
      bus.start   = 1'b1;
      bus.abort   = 1'b1;
      bus.nframes = 8'd1;
      run_to(a + 6);
      chk("t5_startwin", 36'(bus.busy), 36'd1);
      push_frames(18, 1, NS);
      run_to(hpos(19));
      chk("t5_done", 36'(bus.done), 36'd1);
      chk("t5_fc", 36'(bus.frames_captured), 36'd1);
      chk("t5_ndone", 36'(done_cnt), 36'd2);

      // reset mid-capture, relock, single frame
      run_to(hpos(19) + 4);
      bus.start   = 1'b1;
      bus.nframes = 8'd2;
      r = hpos(20) + 17;
      push_frames(20, 2, r);
      run_to(r - 1);
      chk("t6_busy", 36'(bus.busy), 36'd1);
      rst = 1'b1;
      run_to(r);
      chk("t6_locked", 36'(bus.locked), 36'd0);
      chk("t6_busy0", 36'(bus.busy), 36'd0);
      chk("t6_done", 36'(bus.done), 36'd0);
      chk("t6_lerr", 36'(bus.lock_err), 36'd0);
      chk("t6_ovf", 36'(bus.overflow), 36'd0);
      chk("t6_fc", 36'(bus.frames_captured), 36'd0);
      chk("t6_dout", bus.data_out, 36'd0);
      run_to(hpos(24));
      chk("t6_lock_pre", 36'(bus.locked), 36'd0);
      run_to(hpos(24) + 1);
      chk("t6_relock", 36'(bus.locked), 36'd1);
      done_cnt = 0;
      run_to(hpos(25) - 5);
      bus.start   = 1'b1;
      bus.nframes = 8'd1;
      push_frames(25, 1, NS);
      run_to(hpos(26));
      chk("t6_done1", 36'(bus.done), 36'd1);
      chk("t6_fc1", 36'(bus.frames_captured), 36'd1);
      run_to(hpos(26) + 2);
      chk("t6_idle", 36'(bus.busy), 36'd0);
      chk("t6_ndone", 36'(done_cnt), 36'd1);
      chk("missing_wr", 36'(exp_q.size()), 36'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
